// File: rtl/muldiv_unit_if.sv
// Request/response bundle of the iterative multiply/divide unit.
// The core side drives the master modport; the unit uses the slave modport.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       status;
    logic             busy;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, status, busy
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, status, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide/remainder unit, one bit per cycle, with
// valid/ready handshakes and the ALU's {N,Z,C,V} status nibble.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] f_status(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
        f_status = {res[WIDTH-1], (res == ZERO), c, v};
    endfunction

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_status;

    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_accept;
    logic               w_div0;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_fast_res;
    logic [3:0]         w_fast_st;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_mtop;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fin_res;
    logic               w_fin_v;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.status    = r_status;
    assign bus.busy      = r_busy;

    // Operand signedness per funct3: MULHSU treats only rs1 as signed.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (bus.op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'd2: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b0;
            end
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
    end

    assign w_a_neg  = w_a_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_b_signed & bus.b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? (ZERO - bus.a) : bus.a;
    assign w_abs_b  = w_b_neg ? (ZERO - bus.b) : bus.b;
    assign w_accept = bus.in_valid & r_in_ready & ~bus.flush;
    assign w_div0   = bus.op[2] & (bus.b == ZERO);
    assign w_ovf    = bus.op[2] & ~bus.op[0] & (bus.a == MIN_INT) & (bus.b == ONES);

    // Fast-path results for divide-by-zero and MIN_INT / -1.
    always_comb begin
        w_fast_res = ZERO;
        w_fast_st  = 4'b0000;
        if (w_div0) begin
            w_fast_res = bus.op[1] ? bus.a : ONES;
            w_fast_st  = f_status(w_fast_res, 1'b1, 1'b0);
        end else begin
            w_fast_res = bus.op[1] ? ZERO : MIN_INT;
            w_fast_st  = f_status(w_fast_res, 1'b0, 1'b1);
        end
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_mtop    = r_acc[0] ? w_msum : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        w_rsh     = r_acc[2*WIDTH-1:WIDTH-1];
        w_ge      = (w_rsh >= {1'b0, r_mcand});
        w_diff    = w_rsh[WIDTH-1:0] - r_mcand;
        w_acc_nxt = {w_mtop, r_acc[WIDTH-1:1]};
        if (r_op[2]) begin
            if (w_ge) begin
                w_acc_nxt = {w_diff, r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {w_mtop, r_acc[WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg_q ? ({(2*WIDTH){1'b0}} - w_acc_nxt) : w_acc_nxt;

    // Sign fix-up and result selection applied on the last iteration.
    always_comb begin
        w_fin_res = ZERO;
        w_fin_v   = 1'b0;
        if (r_op[2]) begin
            if (r_op[1]) begin
                w_fin_res = r_neg_r ? (ZERO - w_acc_nxt[2*WIDTH-1:WIDTH])
                                    : w_acc_nxt[2*WIDTH-1:WIDTH];
            end else begin
                w_fin_res = r_neg_q ? (ZERO - w_acc_nxt[WIDTH-1:0])
                                    : w_acc_nxt[WIDTH-1:0];
            end
            w_fin_v = 1'b0;
        end else begin
            if (r_op[1:0] == 2'b00) begin
                w_fin_res = w_prod[WIDTH-1:0];
            end else begin
                w_fin_res = w_prod[2*WIDTH-1:WIDTH];
            end
            // The signed product fits in WIDTH bits iff its top WIDTH+1 bits agree.
            if (r_op[1:0] == 2'b11) begin
                w_fin_v = 1'b0;
            end else begin
                w_fin_v = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
            end
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_op        <= 3'd0;
            r_acc       <= {(2*WIDTH){1'b0}};
            r_mcand     <= ZERO;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= ZERO;
            r_status    <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= bus.op;
                        r_acc      <= {ZERO, w_abs_a};
                        r_mcand    <= w_abs_b;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_div0 | w_ovf) begin
                            r_state     <= DONE;
                            r_result    <= w_fast_res;
                            r_status    <= w_fast_st;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        r_state    <= IDLE;
                        r_cnt      <= {CNT_W{1'b0}};
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state     <= DONE;
                            r_result    <= w_fin_res;
                            r_status    <= f_status(w_fin_res, 1'b0, w_fin_v);
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.flush | bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= {CNT_W{1'b0}};
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expectations, a
// monitor checks latency on out_valid rise and data on each result handshake.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   st;
        int           lat;
        int           t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, data on handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                else chk("latency", 32'(cyc - exp_q[0].t), 32'(exp_q[0].lat));
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                chk("result", bus.result, exp_q[0].res);
                chk("status", 32'(bus.status), 32'(exp_q[0].st));
                void'(exp_q.pop_front());
            end
            prev_valid <= bus.out_valid;
        end
    end

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom_range(0, 7));
        bus.a  = $urandom;
        bus.b  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) begin
            chk("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [3:0] st, input int lat);
        exp_t e;
        drive(op, a, b);
        e.res = res; e.st = st; e.lat = lat; e.t = cyc;
        exp_q.push_back(e);
        release_req();
        drain();
    endtask

    task automatic watch_idle(input string name);
        int seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_result"},    bus.result,         32'd0);
        chk({tag, "_status"},    32'(bus.status),    32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 32'd7,          32'd6,          32'd42,         4'b0000, 33);
        issue(3'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  4'b1000, 33);
        issue(3'd3, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  4'b0000, 33);
        issue(3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  4'b1000, 33);
        issue(3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  4'b1000, 33);
        issue(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  4'b1010, 1);
        issue(3'd7, 32'd5,          32'd0,          32'd5,          4'b0010, 1);
        issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  4'b1001, 1);
        issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          4'b0101, 1);
        issue(3'd0, 32'h0001_0000,  32'h0001_0000,  32'd0,          4'b0101, 33);
        issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b1001, 33);
        issue(3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          4'b0000, 33);
        issue(3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  4'b0001, 33);
        issue(3'd4, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  4'b1000, 33);
        issue(3'd6, 32'd100,        32'hFFFF_FFF9,  32'd2,          4'b0000, 33);
        issue(3'd4, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  4'b1010, 1);
        issue(3'd6, 32'h8000_0000,  32'd0,          32'h8000_0000,  4'b1010, 1);

        // Backpressure: result and status must hold while out_ready is low.
        begin
            exp_t e;
            int n = 0;
            bus.out_ready = 1'b0;
            drive(3'd5, 32'hFFFF_FFFF, 32'd16);
            e.res = 32'h0FFF_FFFF; e.st = 4'b0000; e.lat = 33; e.t = cyc;
            exp_q.push_back(e);
            release_req();
            while (!bus.out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("bp_valid_seen", 32'(bus.out_valid), 32'd1);
            repeat (10) begin
                @(negedge clk);
                chk("bp_result_hold", bus.result, 32'h0FFF_FFFF);
                chk("bp_status_hold", 32'(bus.status), 32'd0);
                chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            drain();
            chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
            chk("bp_valid_after", 32'(bus.out_valid), 32'd0);
            issue(3'd7, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 4'b0000, 33);
        end

        // Flush in CALC cycle 5: no result, unit idle on the next cycle.
        drive(3'd0, 32'd9, 32'd9);
        release_req();
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_result_kept", bus.result, 32'h0000_000F);
        watch_idle("flush_no_valid");
        issue(3'd0, 32'd7, 32'd6, 32'd42, 4'b0000, 33);

        // Flush while idle blocks a simultaneous request.
        bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("idle_flush_busy", 32'(bus.busy), 32'd0);
        chk("idle_flush_in_ready", 32'(bus.in_ready), 32'd1);
        watch_idle("idle_flush_no_valid");

        // Asynchronous reset mid-operation.
        drive(3'd4, 32'd100, 32'hFFFF_FFF9);
        release_req();
        repeat (10) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(posedge clk); #1;
        rstn = 1'b1;
        watch_idle("reset_no_valid");
        issue(3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 4'b0000, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
